// File: rtl/led_display_pkg.sv
// Shared types and constants for the LED display datapath.
// Used by the binary-to-BCD converter and its digit adjust cells.
package led_display_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } conv_state_t;

  localparam logic [3:0] BCD_ADJUST_THRESHOLD = 4'd5;
  localparam logic [3:0] BCD_ADJUST_ADD       = 4'd3;
  localparam logic [3:0] BCD_DIGIT_MAX        = 4'h9;

endpackage

// File: rtl/bcd_digit_adjust.sv
// One BCD digit of the shift-and-add-3 step: digits of 5 or more get +3
// so that the following left shift carries correctly into the next digit.
import led_display_pkg::*;

module bcd_digit_adjust (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= BCD_ADJUST_THRESHOLD) ? (digit + BCD_ADJUST_ADD) : digit;

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential binary-to-BCD converter, one bit per clock, feeding the 7-segment driver.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits in digit_enable_mask.
import led_display_pkg::*;

module bin_to_bcd_converter #(
  parameter int BIN_WIDTH     = 20,
  parameter int WIDTH_NIBBLES = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [BIN_WIDTH-1:0]       bin_data,
  input  logic                       bin_valid,
  output logic                       bin_ready,
  output logic [WIDTH_NIBBLES*4-1:0] bcd_data,
  output logic [WIDTH_NIBBLES-1:0]   digit_enable_mask,
  output logic                       bcd_valid,
  output logic                       overflow
);

  localparam int BCD_W = WIDTH_NIBBLES * 4;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_WIDTH - 1);
  localparam logic [BCD_W-1:0] SATURATED  = {WIDTH_NIBBLES{BCD_DIGIT_MAX}};
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [WIDTH_NIBBLES-1:0] MASK_RESET = WIDTH_NIBBLES'(1);
`else
  localparam logic [WIDTH_NIBBLES-1:0] MASK_RESET = '1;
`endif

  conv_state_t              state;
  logic [BIN_WIDTH-1:0]     bin_sr;
  logic [BCD_W-1:0]         acc;
  logic [BCD_W-1:0]         acc_adj;
  logic [BCD_W-1:0]         acc_next;
  logic                     sticky;
  logic                     sticky_next;
  logic [CNT_W-1:0]         cnt;
  logic [WIDTH_NIBBLES-1:0] mask_next;

  for (genvar g = 0; g < WIDTH_NIBBLES; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit   (acc[4*g +: 4]),
      .adjusted(acc_adj[4*g +: 4])
    );
  end

  // The bit leaving the top digit after adjustment means the value no longer fits.
  assign acc_next    = {acc_adj[BCD_W-2:0], bin_sr[BIN_WIDTH-1]};
  assign sticky_next = sticky | acc_adj[BCD_W-1];

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic seen;
    seen      = 1'b0;
    mask_next = '0;
    for (int i = WIDTH_NIBBLES - 1; i >= 0; i--) begin
      seen         = seen | (acc_next[4*i +: 4] != 4'd0);
      mask_next[i] = seen;
    end
    mask_next[0] = 1'b1;
    if (sticky_next) begin
      mask_next = '1;
    end
  end
`else
  assign mask_next = '1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      bin_ready         <= 1'b1;
      bin_sr            <= '0;
      acc               <= '0;
      sticky            <= 1'b0;
      cnt               <= '0;
      bcd_data          <= '0;
      digit_enable_mask <= MASK_RESET;
      bcd_valid         <= 1'b0;
      overflow          <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bin_valid) begin
            state     <= SHIFT;
            bin_ready <= 1'b0;
            bin_sr    <= bin_data;
            acc       <= '0;
            sticky    <= 1'b0;
            cnt       <= '0;
          end
        end
        SHIFT: begin
          acc    <= acc_next;
          bin_sr <= {bin_sr[BIN_WIDTH-2:0], 1'b0};
          sticky <= sticky_next;
          cnt    <= cnt + CNT_W'(1);
          // Final shift: publish the result and hand the input back.
          if (cnt == LAST_SHIFT) begin
            state             <= IDLE;
            bin_ready         <= 1'b1;
            bcd_data          <= sticky_next ? SATURATED : acc_next;
            overflow          <= sticky_next;
            digit_enable_mask <= mask_next;
            bcd_valid         <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          bin_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Directed-vector bench for bin_to_bcd_converter with hand-computed results;
// expected masks follow LEADING_ZERO_BLANK_EN when it is defined.
`timescale 1ns/1ps

module tb_bin_to_bcd_converter;

  logic        clk;
  logic        reset;
  logic [19:0] bin_data;
  logic        bin_valid;
  logic        bin_ready;
  logic [23:0] bcd_data;
  logic [5:0]  digit_enable_mask;
  logic        bcd_valid;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  bin_to_bcd_converter #(.BIN_WIDTH(20), .WIDTH_NIBBLES(6)) dut (
    .clk              (clk),
    .reset            (reset),
    .bin_data         (bin_data),
    .bin_valid        (bin_valid),
    .bin_ready        (bin_ready),
    .bcd_data         (bcd_data),
    .digit_enable_mask(digit_enable_mask),
    .bcd_valid        (bcd_valid),
    .overflow         (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [5:0] expMask(input logic [5:0] blanked);
`ifdef LEADING_ZERO_BLANK_EN
    return blanked;
`else
    return 6'b111111;
`endif
  endfunction

  // Counts edges until bcd_valid is seen at a falling edge, bounded at 40.
  task automatic waitResult(output int edges);
    logic seen;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      seen = bcd_valid;
    end
  endtask

  task automatic checkResult(input string tag, input logic [23:0] exp_bcd,
                             input logic [5:0] exp_blank, input logic exp_ovf);
    checkOutput({tag, "_data"}, 32'(bcd_data), 32'(exp_bcd));
    checkOutput({tag, "_mask"}, 32'(digit_enable_mask), 32'(expMask(exp_blank)));
    checkOutput({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    checkOutput({tag, "_ready"}, 32'(bin_ready), 32'd1);
  endtask

  task automatic applyStimulus(input string tag, input logic [19:0] value, input logic [23:0] exp_bcd,
                               input logic [5:0] exp_blank, input logic exp_ovf);
    int edges;
    @(negedge clk);
    checkOutput({tag, "_idle"}, 32'(bin_ready), 32'd1);
    bin_data  = value;
    bin_valid = 1'b1;
    @(posedge clk);
    #1 bin_valid = 1'b0;
    waitResult(edges);
    checkOutput({tag, "_latency"}, 32'(edges), 32'd20);
    checkResult(tag, exp_bcd, exp_blank, exp_ovf);
    @(negedge clk);
    checkOutput({tag, "_pulse"}, 32'(bcd_valid), 32'd0);
  endtask

  initial begin
    int edges;
    int pulses;

    reset     = 1'b1;
    bin_data  = '0;
    bin_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", 32'(bin_ready), 32'd1);
    checkOutput("rst_data", 32'(bcd_data), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    checkOutput("rst_valid", 32'(bcd_valid), 32'd0);
    checkOutput("rst_mask", 32'(digit_enable_mask), 32'(expMask(6'b000001)));
    reset = 1'b0;

    applyStimulus("zero",    20'd0,       24'h000000, 6'b000001, 1'b0);
    applyStimulus("v255",    20'd255,     24'h000255, 6'b000111, 1'b0);
    applyStimulus("v123456", 20'd123456,  24'h123456, 6'b111111, 1'b0);
    applyStimulus("v999999", 20'd999999,  24'h999999, 6'b111111, 1'b0);
    applyStimulus("v1e6",    20'd1000000, 24'h999999, 6'b111111, 1'b1);
    applyStimulus("vmax",    20'd1048575, 24'h999999, 6'b111111, 1'b1);
    applyStimulus("v9",      20'd9,       24'h000009, 6'b000001, 1'b0);

    // bin_valid held high: 7 then 42, accepts 21 cycles apart
    @(negedge clk);
    bin_data  = 20'd7;
    bin_valid = 1'b1;
    @(posedge clk);
    waitResult(edges);
    checkOutput("held_first_latency", 32'(edges), 32'd20);
    checkResult("held_first", 24'h000007, 6'b000001, 1'b0);
    bin_data = 20'd42;
    waitResult(edges);
    checkOutput("held_spacing", 32'(edges), 32'd21);
    checkResult("held_second", 24'h000042, 6'b000011, 1'b0);
    bin_valid = 1'b0;
    repeat (25) @(posedge clk);

    // bin_valid pulsed during SHIFT must be ignored
    @(negedge clk);
    bin_data  = 20'd123456;
    bin_valid = 1'b1;
    @(posedge clk);
    #1 bin_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("busy_ready", 32'(bin_ready), 32'd0);
    bin_data  = 20'd999;
    bin_valid = 1'b1;
    @(posedge clk);
    #1 bin_valid = 1'b0;
    waitResult(edges);
    checkOutput("busy_latency", 32'(edges), 32'd15);
    checkResult("busy", 24'h123456, 6'b111111, 1'b0);

    // Reset asserted on E10 of a conversion
    @(negedge clk);
    bin_data  = 20'd123456;
    bin_valid = 1'b1;
    @(posedge clk);
    #1 bin_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_ready", 32'(bin_ready), 32'd1);
    checkOutput("abort_data", 32'(bcd_data), 32'd0);
    checkOutput("abort_ovf", 32'(overflow), 32'd0);
    checkOutput("abort_mask", 32'(digit_enable_mask), 32'(expMask(6'b000001)));
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bcd_valid) pulses++;
    end
    checkOutput("abort_no_valid", 32'(pulses), 32'd0);

    applyStimulus("after_abort", 20'd255, 24'h000255, 6'b000111, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
